// File: rtl/compute_tile_v2.sv
// compute_tile_v2: CGRA compute tile. It has a 4-entry weight bank, a
// five-mode saturating ALU with a MAC accumulator, and valid/ready handshakes.
// Results pass through one registered output stage that honours backpressure.
// Each result carries the destination tag that was configured when the result
// was generated.
module compute_tile_v2 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_dest,
  output logic              out_has_dest,
  output logic [7:0]        op_count
);

  localparam int OPW = DATA_W - 4;
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_MAC = 3'b011;
  localparam logic [2:0] OP_MAX = 3'b100;

  typedef enum logic [1:0] {
    PKT_WLOAD  = 2'b00,
    PKT_CONFIG = 2'b01,
    PKT_DATA   = 2'b10,
    PKT_CTRL   = 2'b11
  } pkt_t;

  logic [OPW-1:0]    r_weight [4];
  logic [2:0]        r_opcode;
  logic [1:0]        r_dest;
  logic              r_has_dest;
  logic [ACC_W-1:0]  r_acc;
  logic [7:0]        r_op_count;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_dest;
  logic              r_out_has_dest;

  pkt_t              w_type;
  logic [1:0]        w_sel;
  logic              w_accept;
  logic              w_emit;
  logic [ACC_W-1:0]  w_opnd;
  logic [ACC_W-1:0]  w_wt;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_diff;
  logic [ACC_W-1:0]  w_prod;
  logic [ACC_W-1:0]  w_mac_sum;
  logic [DATA_W-1:0] w_alu;

  // Clamp a wide intermediate value into the unsigned result range.
  function automatic logic [DATA_W-1:0] sat(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] c;
    c = (v > SAT_MAX) ? SAT_MAX : v;
    return c[DATA_W-1:0];
  endfunction

  assign w_type    = pkt_t'(in_data[DATA_W-1:DATA_W-2]);
  assign w_sel     = in_data[DATA_W-3:DATA_W-4];
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = w_accept && ((w_type == PKT_DATA) || ((w_type == PKT_CTRL) && in_data[1]));
  assign w_opnd    = ACC_W'(in_data[OPW-1:0]);
  assign w_wt      = ACC_W'(r_weight[w_sel]);
  assign w_sum     = w_opnd + w_wt;
  assign w_diff    = w_opnd - w_wt;
  assign w_prod    = w_opnd * w_wt;
  assign w_mac_sum = r_acc + w_prod;

  // ALU: select the saturated result of the configured operation.
  always_comb begin
    w_alu = '0;
    case (r_opcode)
      OP_ADD:  w_alu = sat(w_sum);
      OP_SUB:  w_alu = (w_opnd >= w_wt) ? sat(w_diff) : '0;
      OP_MUL:  w_alu = sat(w_prod);
      OP_MAC:  w_alu = sat(w_mac_sum);
      OP_MAX:  w_alu = (w_opnd >= w_wt) ? sat(w_opnd) : sat(w_wt);
      default: w_alu = sat(w_opnd);
    endcase
  end

  // Weight bank and configuration registers, written by accepted WLOAD/CONFIG packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_weight[i] <= '0;
      r_opcode   <= OP_ADD;
      r_dest     <= '0;
      r_has_dest <= 1'b0;
    end else if (w_accept) begin
      if (w_type == PKT_WLOAD) begin
        r_weight[w_sel] <= in_data[OPW-1:0];
      end else if (w_type == PKT_CONFIG) begin
        r_dest     <= w_sel;
        r_has_dest <= in_data[OPW-1];
        r_opcode   <= in_data[2:0];
      end
    end
  end

  // Accumulator: MAC loads the saturated sum, CTRL clear or flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      if ((w_type == PKT_DATA) && (r_opcode == OP_MAC))
        r_acc <= ACC_W'(w_alu);
      else if ((w_type == PKT_CTRL) && (in_data[0] || in_data[1]))
        r_acc <= '0;
    end
  end

  // Count accepted DATA packets; the 8-bit counter wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_op_count <= '0;
    else if (w_accept && (w_type == PKT_DATA))
      r_op_count <= r_op_count + 8'd1;
  end

  // Output stage: load a new result, drain on out_ready, otherwise hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_dest     <= '0;
      r_out_has_dest <= 1'b0;
    end else if (w_emit) begin
      r_out_valid    <= 1'b1;
      r_out_data     <= (w_type == PKT_DATA) ? w_alu : r_acc[DATA_W-1:0];
      r_out_dest     <= r_dest;
      r_out_has_dest <= r_has_dest;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_dest     = r_out_dest;
  assign out_has_dest = r_out_has_dest;
  assign op_count     = r_op_count;

endmodule

// File: doc/compute_tile_v2.md
Name: compute_tile_v2

Overview:
- Parametrised next-generation CGRA compute tile. Consumes a stream of typed DATA_W-bit packets from the switch and produces result packets back to the switch.
- Adds over the first-generation tile: a 4-entry weight bank, five ALU modes including MAC with an accumulator, and saturating arithmetic.
- Adds valid/ready handshakes on both sides, a registered output stage with backpressure, and destination tagging for chaining to the next tile.

Parameters:
- DATA_W, 8, packet and result width; must be >= 8. Derived OPW = DATA_W-4 (operand/weight width).
- ACC_W, 2*DATA_W, internal accumulator width. Accumulator saturates at 2^DATA_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  switch packet valid
- in_ready  out  1  tile accepts packet
- in_data  in  DATA_W  packet
- out_valid  out  1  result valid
- out_ready  in  1  switch accepts result
- out_data  out  DATA_W  result
- out_dest  out  2  next core index tagged on result
- out_has_dest  out  1  result is forwarded to out_dest
- op_count  out  8  number of data packets processed, wraps at 255

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is asynchronous, active-low (rst_n).
  - Reset clears all weights, the accumulator, opcode (ADD), dest, has_dest, op_count and out_data to 0, and out_valid to 0.
  - Reset mid-transfer drops the pending result.
- Packet fields, with T = in_data[DATA_W-1:DATA_W-2] and S = in_data[DATA_W-3:DATA_W-4]:
  - T=00, WLOAD: weight[S] <= in_data[OPW-1:0].
  - T=01, CONFIG: dest <= S; has_dest <= in_data[OPW-1]; opcode <= in_data[2:0].
  - T=10, DATA: operand = in_data[OPW-1:0]; w = weight[S].
  - T=11, CTRL: bit0 = clear accumulator; bit1 = flush (emit accumulator, then clear it).
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and independent of in_data.
  - A packet is accepted when in_valid && in_ready. All packet types obey this rule, which preserves ordering.
  - Only DATA and CTRL-with-flush packets produce a result. The result is registered: out_valid rises the cycle after acceptance (latency 1).
  - out_data, out_dest and out_has_dest hold stable while out_valid && !out_ready.
  - When out_ready is high, a new packet can be accepted in the same cycle the old result drains. This gives full throughput of 1 packet/cycle.
  - WLOAD and CONFIG take effect on the cycle after acceptance. A DATA packet in the next accepted slot sees the new value.
- Opcodes, all results clamped to the range [0, 2^DATA_W-1]:
  - 000 ADD: operand + w.
  - 001 SUB: operand - w, clamped to 0 if negative.
  - 010 MUL: operand * w, saturated.
  - 011 MAC: acc <= sat(acc + operand*w); the result is the new acc.
  - 100 MAX: max(operand, w).
  - 101-111 PASS: operand.
- Accumulator:
  - Non-MAC ops leave acc unchanged.
  - Flush result is the current acc, tagged with the current dest/has_dest. Acc becomes 0.
  - CTRL with bits0 and 1 both set behaves as flush. CTRL with bit0 only produces no output.
  - CTRL with neither bit set is a no-op but is still accepted.
- op_count increments on every accepted DATA packet and wraps 255 -> 0.
- Result tagging: out_dest and out_has_dest are captured from the config at result-generation time, not at drain time.
- Configuration persists until it is overwritten or reset.

Test Plan (DATA_W=8):
- Reset, then WLOAD 0x03 (w0=3), CONFIG 0x68 (ADD, dest=2, has_dest=1), DATA 0x85 -> one cycle later out_valid=1, out_data=8, out_dest=2, out_has_dest=1, op_count=1.
- CONFIG 0x69 (SUB), DATA 0x82 (2-3) -> out_data=0 (clamped). DATA 0x8F -> out_data=12.
- WLOAD 0x1F (w1=15), CONFIG 0x6A (MUL), DATA 0x9F -> out_data=0xE1 (225). CONFIG 0x6B (MAC), DATA 0x9F twice -> out_data 225 then 255 (saturated). CTRL 0xC2 -> out_data=255; next MAC DATA 0x9F -> 225 (acc was cleared).
- Hold out_ready=0 with a result pending and in_valid=1 -> in_ready=0, out_data stable for 5 cycles, no packet lost. Raise out_ready with back-to-back DATA packets -> one result per cycle, in order.
- Assert rst_n=0 mid-stream with out_valid=1 -> out_valid drops immediately (asynchronously), weights read 0, and after release DATA 0x85 gives out_data=5 (ADD, w0=0).
- Send 256 DATA packets -> op_count wraps to 0. CONFIG 0x6C (MAX) with w0=3, DATA 0x81 -> out_data=3. CTRL 0xC0 -> no output, in_ready stays 1.
